// File: rtl/debounce_pkg.sv
// Shared types and limits for the three-channel input debouncer.
package debounce_pkg;

    localparam int NUM_CH   = 3;
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;

    typedef enum logic [0:0] {
        STABLE  = 1'b0,
        CONFIRM = 1'b1
    } deb_state_t;

    // Clamp a requested synchroniser depth into the supported range.
    function automatic int clamp_sync_stages(input int n);
        if (n < SYNC_MIN) begin
            return SYNC_MIN;
        end else if (n > SYNC_MAX) begin
            return SYNC_MAX;
        end else begin
            return n;
        end
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser chain, STABLE/CONFIRM FSM, counter and
// registered rise/fall pulses. o_state_nxt feeds the top-level all_stable flop.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_raw,
    input  logic       i_tick,
    output logic       o_level,
    output logic       o_rise,
    output logic       o_fall,
    output deb_state_t o_state_nxt
);

    localparam int               SYNC_N   = clamp_sync_stages(SYNC_STAGES);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam bit               ONE_SHOT = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_N-1:0] r_sync;
    deb_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out;
    logic              r_rise;
    logic              r_fall;

    logic              w_s;
    deb_state_t        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_out_nxt;
    logic              w_rise_nxt;
    logic              w_fall_nxt;

    assign w_s = r_sync[SYNC_N-1];

    // Synchroniser chain; only its last stage is ever looked at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_N-2:0], i_raw};
        end
    end

    // FSM state, counter, level and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= STABLE;
            r_cnt   <= CNT_ZERO;
            r_out   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Next state: glitch check runs every clock, counting only on tick.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        case (r_state)
            STABLE: begin
                if (w_s != r_out) begin
                    if (i_tick) begin
                        if (ONE_SHOT) begin
                            w_out_nxt   = w_s;
                            w_cnt_nxt   = CNT_ZERO;
                            w_state_nxt = STABLE;
                        end else begin
                            w_cnt_nxt   = CNT_ONE;
                            w_state_nxt = CONFIRM;
                        end
                    end else begin
                        w_cnt_nxt   = CNT_ZERO;
                        w_state_nxt = CONFIRM;
                    end
                end else begin
                    w_cnt_nxt = CNT_ZERO;
                end
            end
            CONFIRM: begin
                if (w_s == r_out) begin
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = STABLE;
                end else if (i_tick) begin
                    if (r_cnt == CNT_LAST) begin
                        w_out_nxt   = w_s;
                        w_cnt_nxt   = CNT_ZERO;
                        w_state_nxt = STABLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            default: begin
                w_cnt_nxt   = CNT_ZERO;
                w_state_nxt = STABLE;
            end
        endcase
    end

    // Pulses are taken from the level change so they land with the new level.
    always_comb begin
        w_rise_nxt = 1'b0;
        w_fall_nxt = 1'b0;
        if (w_out_nxt != r_out) begin
            w_rise_nxt = w_out_nxt;
            w_fall_nxt = ~w_out_nxt;
        end else begin
            w_rise_nxt = 1'b0;
            w_fall_nxt = 1'b0;
        end
    end

    assign o_level     = r_out;
    assign o_rise      = r_rise;
    assign o_fall      = r_fall;
    assign o_state_nxt = w_state_nxt;

endmodule

// File: rtl/input_debounce_3ch.sv
// Three independent synchronise-and-debounce channels producing clean a/b/c
// levels, per-channel edge pulses and a registered all-stable flag.
module input_debounce_3ch
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] raw_in,
    input  logic              tick,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic              all_stable
);

    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_fall;
    deb_state_t        w_state_nxt [NUM_CH];
    logic              w_all_stable_nxt;
    logic              r_all_stable;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_raw       (raw_in[g]),
            .i_tick      (tick),
            .o_level     (w_level[g]),
            .o_rise      (w_rise[g]),
            .o_fall      (w_fall[g]),
            .o_state_nxt (w_state_nxt[g])
        );
    end

    // Built from next-state so the flag tracks the channel state registers.
    always_comb begin
        w_all_stable_nxt = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_state_nxt[i] != STABLE) begin
                w_all_stable_nxt = 1'b0;
            end else begin
                w_all_stable_nxt = w_all_stable_nxt;
            end
        end
    end

    // all_stable register; idle channels are stable so reset value is 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_all_stable <= 1'b1;
        end else begin
            r_all_stable <= w_all_stable_nxt;
        end
    end

    assign a          = w_level[0];
    assign b          = w_level[1];
    assign c          = w_level[2];
    assign rise       = w_rise;
    assign fall       = w_fall;
    assign all_stable = r_all_stable;

endmodule

// File: doc/input_debounce_3ch.md
Name: input_debounce_3ch

Overview:
- Upstream conditioning stage for the registered (a | b) & c logic stage.
- Takes three asynchronous raw inputs, synchronises each into clk, debounces each, and drives clean levels on a, b and c for the downstream stage.
- Also produces one-cycle rise/fall event pulses per channel and an all-stable flag.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per channel (legal range 2..4)
DEBOUNCE_CYCLES, 16, consecutive counted cycles the new level must persist before the output changes (legal range >= 1)
CNT_W, $clog2(DEBOUNCE_CYCLES)+1, debounce counter width (derived, not overridden)

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
raw_in  input  3  asynchronous raw inputs; bit0->a, bit1->b, bit2->c
tick  input  1  counter advance enable; tie 1 for per-clock debounce
a  output  1  debounced, synchronised level of raw_in[0]
b  output  1  debounced, synchronised level of raw_in[1]
c  output  1  debounced, synchronised level of raw_in[2]
rise  output  3  one-cycle pulse when the corresponding output goes 0->1
fall  output  3  one-cycle pulse when the corresponding output goes 1->0
all_stable  output  1  1 when every channel is in STABLE state

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous, active-high. All flops clear on rst assertion, independent of clk.
- Reset values:
  - a, b, c = 0; rise = 0; fall = 0; all_stable = 1.
  - Sync flops = 0, counters = 0, states = STABLE.
- Synchroniser:
  - SYNC_STAGES-flop chain per channel. Its output s is the only signal the FSM uses. No combinational path from raw_in to any output.
- Per-channel FSM, states STABLE and CONFIRM; out is the channel's output level:
  - STABLE, s == out: hold; cnt = 0.
  - STABLE, s != out: go to CONFIRM. If tick = 1, cnt = 1, else cnt = 0. If DEBOUNCE_CYCLES == 1 and tick = 1, out <= s immediately and stay in STABLE.
  - CONFIRM, s == out (glitch): go to STABLE, cnt = 0, out unchanged, no pulse. Glitch detection runs every clock regardless of tick.
  - CONFIRM, s != out, tick = 1, cnt < DEBOUNCE_CYCLES-1: cnt++.
  - CONFIRM, s != out, tick = 1, cnt == DEBOUNCE_CYCLES-1: out <= s, cnt = 0, go to STABLE. Pulse rise or fall (by new value) in the same cycle out changes.
  - CONFIRM, tick = 0: cnt holds.
- Latency, tick = 1:
  - A clean raw level change first sampled at edge 1 appears on the output at edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - Defaults give edge 18.
- Pulses: rise/fall are registered, exactly one cycle wide, never both set on the same channel.
- all_stable: registered; 0 whenever any channel is in CONFIRM.
- Channel independence: channels are fully independent. Simultaneous events on different channels each produce their own pulse in the same cycle.
- Counter: saturating logic not required; cnt never exceeds DEBOUNCE_CYCLES-1 by construction. No wrap-around.
- Reset mid-CONFIRM:
  - All state clears and outputs drop to 0.
  - No pulse is generated by reset itself.
  - An input held high through reset release needs the full SYNC_STAGES+DEBOUNCE_CYCLES latency to reach 1, and then produces a rise pulse.

Decomposition:
- Package debounce_pkg:
  - NUM_CH = 3.
  - State typedef deb_state_t {STABLE, CONFIRM}.
  - Parameter legality limits: SYNC_MIN = 2, SYNC_MAX = 4.
- Sub-module debounce_ch: one channel containing synchroniser, FSM, counter and pulse generation.
- Top level instantiates debounce_ch three times and maps outputs to a, b, c. all_stable is registered in the top level from the per-channel state.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with raw_in = 3'b111 -> a, b, c, rise and fall drop to 0 immediately, all_stable = 1.
- Clean edge, defaults, tick = 1: raw_in[0] 0->1 held -> a = 1 at the 18th edge, rise[0] = 1 for exactly that cycle, all_stable = 0 from edge 3 to edge 17.
- Glitch: raw_in[1] high for 10 cycles, then low -> b stays 0, no rise/fall pulse, channel returns to STABLE.
- Tick gating: tick pulsed 1-in-4, raw_in[2] 0->1 -> c rises after 16 tick-qualified counts (about 64 cycles plus sync). Counter holds between ticks.
- Simultaneous: raw_in 3'b000->3'b101, then later 3'b101->3'b000 -> rise = 3'b101 in one cycle on rise, fall = 3'b101 in one cycle on fall.
- Reset mid-CONFIRM: rst pulsed at count 8 with raw_in[0] held 1 -> a = 0, no pulse during reset. a rises a full 18 edges after release, with a rise pulse.
